// File: rtl/alu_pkg.sv
// ALU control codes, flag bit positions and ctrl legality helper
// shared by the ALU share arbiter and its ALU datapath.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam int FLG_V = 3;
    localparam int FLG_C = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;

    function automatic logic is_legal_ctrl(input logic [2:0] ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB) ||
               (ctrl == ALU_AND) || (ctrl == ALU_OR)  ||
               (ctrl == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU: add, sub, and, or, slt.
// Ports: A, B operands; ALUControl code; Result; V, C, Z, N flags.
module alu_share_arbiter_alu
    import alu_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUControl,
    output logic [31:0] Result,
    output logic        V,
    output logic        C,
    output logic        Z,
    output logic        N
);

    logic [31:0] w_sum;
    logic [31:0] w_diff;

    assign w_sum  = A + B;
    assign w_diff = A - B;

    always_comb begin
        Result = '0;
        V      = 1'b0;
        case (ALUControl)
            ALU_ADD: begin
                Result = w_sum;
                V      = (A[31] == B[31]) && (w_sum[31] != A[31]);
            end
            ALU_SUB: begin
                Result = w_diff;
                V      = (A[31] != B[31]) && (w_diff[31] != A[31]);
            end
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_SLT: Result = {31'b0, $signed(A) < $signed(B)};
            // Unsupported codes yield zero so Z reads 1.
            default: Result = '0;
        endcase
    end

    // This ALU never reports a carry.
    assign C = 1'b0;
    assign Z = (Result == '0);
    assign N = Result[31];

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// one-entry response register. Ports: clk, rst (async active-low),
// req0_*/req1_* valid/ready request ports, rsp_* valid/ready response.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter bit RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_ctrl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_illegal
);

    logic              r_last_grant;
    logic              r_valid;
    logic              r_id;
    logic [DATA_W-1:0] r_result;
    logic [3:0]        r_flags;
    logic              r_illegal;

    logic              w_free;
    logic              w_grant;
    logic              w_accept;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [2:0]        w_ctrl;
    logic [DATA_W-1:0] w_result;
    logic [3:0]        w_flags;
    logic              w_v;
    logic              w_c;
    logic              w_z;
    logic              w_n;

    assign w_free = !r_valid || rsp_ready;

    // Lone requester wins; on a tie the port not granted last wins.
    // Idle defaults to port 0 so the operand mux rests on port 0.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid)
            w_grant = !r_last_grant;
        else if (req1_valid)
            w_grant = 1'b1;
    end

    assign req0_ready = w_free && (w_grant == 1'b0);
    assign req1_ready = w_free && (w_grant == 1'b1);

    assign w_accept = (req0_valid && req0_ready) ||
                      (req1_valid && req1_ready);

    assign w_a    = w_grant ? req1_a    : req0_a;
    assign w_b    = w_grant ? req1_b    : req0_b;
    assign w_ctrl = w_grant ? req1_ctrl : req0_ctrl;

    alu_share_arbiter_alu u_alu (
        .A          (w_a),
        .B          (w_b),
        .ALUControl (w_ctrl),
        .Result     (w_result),
        .V          (w_v),
        .C          (w_c),
        .Z          (w_z),
        .N          (w_n)
    );

    always_comb begin
        w_flags        = '0;
        w_flags[FLG_V] = w_v;
        w_flags[FLG_C] = w_c;
        w_flags[FLG_Z] = w_z;
        w_flags[FLG_N] = w_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= !RR_INIT;
            r_valid      <= 1'b0;
            r_id         <= 1'b0;
            r_result     <= '0;
            r_flags      <= '0;
            r_illegal    <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
            r_valid      <= 1'b1;
            r_id         <= w_grant;
            r_result     <= w_result;
            r_flags      <= w_flags;
            r_illegal    <= !is_legal_ctrl(w_ctrl);
        end else if (rsp_ready) begin
            // Drain only; data outputs keep their last values.
            r_valid <= 1'b0;
        end
    end

    assign rsp_valid   = r_valid;
    assign rsp_id      = r_id;
    assign rsp_result  = r_result;
    assign rsp_flags   = r_flags;
    assign rsp_illegal = r_illegal;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table plus
// round-robin, backpressure and mid-operation reset sequences.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [2:0]  req0_ctrl;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [2:0]  req1_ctrl;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_illegal;

    int checks;
    int failures;

    alu_share_arbiter #(.DATA_W(32), .RR_INIT(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ctrl   (req0_ctrl),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ctrl   (req1_ctrl),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .rsp_illegal (rsp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        ill;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    logic [31:0] held_res;
    logic [3:0]  held_flg;

    initial begin
        checks   = 0;
        failures = 0;
        rst        = 1'b0;
        rsp_ready  = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_a = '0; req1_b = '0; req1_ctrl = '0;

        // port, a, b, ctrl, result, {V,C,Z,N}, illegal
        vecs[0]  = '{1'b0, 32'd5, 32'd7, 3'b000, 32'd12, 4'b0000, 1'b0};
        vecs[1]  = '{1'b1, 32'h8000_0000, 32'd1, 3'b001,
                     32'h7FFF_FFFF, 4'b1000, 1'b0};
        vecs[2]  = '{1'b0, 32'd3, 32'd5, 3'b101, 32'd1, 4'b0000, 1'b0};
        vecs[3]  = '{1'b0, 32'd5, 32'd3, 3'b101, 32'd0, 4'b0010, 1'b0};
        vecs[4]  = '{1'b1, 32'd9, 32'd9, 3'b110, 32'd0, 4'b0010, 1'b1};
        vecs[5]  = '{1'b0, 32'h0000_F0F0, 32'h0000_FF00, 3'b010,
                     32'h0000_F000, 4'b0000, 1'b0};
        vecs[6]  = '{1'b1, 32'h8000_0000, 32'd1, 3'b011,
                     32'h8000_0001, 4'b0001, 1'b0};
        vecs[7]  = '{1'b0, 32'h7FFF_FFFF, 32'd1, 3'b000,
                     32'h8000_0000, 4'b1001, 1'b0};
        vecs[8]  = '{1'b0, 32'hFFFF_FFFF, 32'd1, 3'b000,
                     32'd0, 4'b0010, 1'b0};
        vecs[9]  = '{1'b1, 32'd5, 32'd5, 3'b001, 32'd0, 4'b0010, 1'b0};
        vecs[10] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 3'b101,
                     32'd1, 4'b0000, 1'b0};
        vecs[11] = '{1'b1, 32'd4, 32'd2, 3'b100, 32'd0, 4'b0010, 1'b1};
        vecs[12] = '{1'b0, 32'd1, 32'd1, 3'b111, 32'd0, 4'b0010, 1'b1};

        // Reset state
        tick();
        tick();
        chk("reset_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_result", rsp_result, 32'd0);
        chk("reset_flags", {28'b0, rsp_flags}, 32'd0);
        chk("reset_id", {31'b0, rsp_id}, 32'd0);
        chk("reset_illegal", {31'b0, rsp_illegal}, 32'd0);
        rst = 1'b1;
        tick();

        // Round robin: both valid, ids alternate 0,1,0,1 with no gaps
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd1;  req0_ctrl = 3'b000;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd10; req1_ctrl = 3'b000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_valid", {31'b0, rsp_valid}, 32'd1);
            chk("rr_id", {31'b0, rsp_id}, i % 2);
            chk("rr_result", rsp_result, (i % 2) ? 32'd20 : 32'd2);
        end
        idle_inputs();

        // Vector table, one port at a time
        for (int i = 0; i < 13; i++) begin
            rsp_ready = 1'b1;
            if (vecs[i].port) begin
                req1_valid = 1'b1; req1_a = vecs[i].a;
                req1_b = vecs[i].b; req1_ctrl = vecs[i].ctrl;
                req0_valid = 1'b0;
                req0_a = 32'hDEAD_BEEF; req0_b = 32'h1234_5678;
                req0_ctrl = 3'b000;
            end else begin
                req0_valid = 1'b1; req0_a = vecs[i].a;
                req0_b = vecs[i].b; req0_ctrl = vecs[i].ctrl;
                req1_valid = 1'b0;
                req1_a = 32'hDEAD_BEEF; req1_b = 32'h1234_5678;
                req1_ctrl = 3'b001;
            end
            #1;
            chk("vec_ready",
                {31'b0, vecs[i].port ? req1_ready : req0_ready}, 32'd1);
            tick();
            idle_inputs();
            chk("vec_valid", {31'b0, rsp_valid}, 32'd1);
            chk("vec_result", rsp_result, vecs[i].res);
            chk("vec_flags", {28'b0, rsp_flags}, {28'b0, vecs[i].flg});
            chk("vec_id", {31'b0, rsp_id}, {31'b0, vecs[i].port});
            chk("vec_illegal", {31'b0, rsp_illegal}, {31'b0, vecs[i].ill});
        end

        // Drain with no accept: valid clears, data holds
        tick();
        chk("drain_valid", {31'b0, rsp_valid}, 32'd0);
        chk("drain_hold", rsp_result, 32'd0);
        chk("drain_ill", {31'b0, rsp_illegal}, 32'd1);

        // Backpressure
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_ctrl = 3'b000;
        tick();
        chk("bp_first", rsp_result, 32'd12);
        rsp_ready  = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd5; req1_ctrl = 3'b001;
        held_res = rsp_result;
        held_flg = rsp_flags;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready0", {31'b0, req0_ready}, 32'd0);
            chk("bp_ready1", {31'b0, req1_ready}, 32'd0);
            tick();
            chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_result", rsp_result, held_res);
            chk("bp_flags", {28'b0, rsp_flags}, {28'b0, held_flg});
            chk("bp_id", {31'b0, rsp_id}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_ready1", {31'b0, req1_ready}, 32'd1);
        chk("bp_rel_ready0", {31'b0, req0_ready}, 32'd0);
        tick();
        chk("bp_swap_valid", {31'b0, rsp_valid}, 32'd1);
        chk("bp_swap_id", {31'b0, rsp_id}, 32'd1);
        chk("bp_swap_result", rsp_result, 32'd15);
        tick();
        chk("bp_next_id", {31'b0, rsp_id}, 32'd0);

        // Reset mid-operation, last grant now port 0
        idle_inputs();
        rsp_ready = 1'b0;
        #2;
        chk("pre_rst_valid", {31'b0, rsp_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_rst_result", rsp_result, 32'd0);
        chk("mid_rst_flags", {28'b0, rsp_flags}, 32'd0);
        chk("mid_rst_id", {31'b0, rsp_id}, 32'd0);
        chk("mid_rst_ill", {31'b0, rsp_illegal}, 32'd0);
        tick();
        rst = 1'b1;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_ctrl = 3'b000;
        req1_valid = 1'b1; req1_a = 32'd8; req1_b = 32'd1; req1_ctrl = 3'b001;
        #1;
        chk("post_rst_ready0", {31'b0, req0_ready}, 32'd1);
        chk("post_rst_ready1", {31'b0, req1_ready}, 32'd0);
        tick();
        chk("post_rst_id", {31'b0, rsp_id}, 32'd0);
        chk("post_rst_result", rsp_result, 32'd5);
        tick();
        chk("post_rst_id2", {31'b0, rsp_id}, 32'd1);
        chk("post_rst_result2", rsp_result, 32'd7);
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single 32-bit ALU between two requesters, e.g. the execute stage (port 0) and the branch/address-compare unit (port 1). Uses round-robin arbitration with valid/ready handshakes on both request ports and on the response port. Each granted operation passes through the ALU combinationally, and the result and flags are captured in a one-entry response register. Sits in the execute stage, between the ID/EX pipeline register and the ALU.

## Interface
- DATA_W, 32, operand/result width; only 32 is supported.
- RR_INIT, 0, port that wins the first tie after reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present on port 0 / 1.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid && ready.
- req0_a, req0_b / req1_a, req1_b  in  32  operands.
- req0_ctrl / req1_ctrl  in  3  ALU control code.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  port that issued the held result.
- rsp_result  out  32  ALU result.
- rsp_flags  out  4  {V,C,Z,N} from the ALU.
- rsp_illegal  out  1  ctrl code was 100, 110 or 111.

## Operation
- Response register is free when `!rsp_valid || rsp_ready`.
- Grant rule:
  - Only one valid port: it wins.
  - Both ports valid: the port not in last_grant wins.
  - last_grant resets to !RR_INIT.
- `reqN_ready = free && grant==N`. The ready outputs are combinational in rsp_ready and the other port's valid.
- On accept (valid && ready):
  - The granted operands and ctrl drive the ALU.
  - rsp_result, rsp_flags, rsp_id and rsp_illegal load, and rsp_valid sets.
  - last_grant is set to the granted port.
- On rsp_ready && rsp_valid with no accept: rsp_valid clears. The data outputs hold their last values.
- Pass-through ctrl codes: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- Codes 100, 110 and 111 are still accepted. The ALU returns result 0 with Z=1, and rsp_illegal=1.
- Flags are the ALU's flags unmodified. C reads 0 for every code.
- While the ALU is not granted its operand mux drives port 0's inputs. This is don't-care.

## Timing
- Reset values: rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_id=0, rsp_illegal=0, last_grant=!RR_INIT.
- Reset asserted mid-operation discards any held response immediately.
- Latency: accept in cycle T gives rsp_valid=1 in T+1.
- Throughput: one operation per cycle while rsp_ready=1.
- Backpressure: with rsp_valid=1 and rsp_ready=0, both ready outputs are 0. All rsp_* outputs stay stable until the handshake completes.
- Simultaneous drain and accept in one cycle: the new result replaces the old one and rsp_valid stays 1.
- A request held while the other port is granted is never lost. It is served no later than the next accept.
- Starvation bound: one accept of the other port.
- Request inputs are only sampled on an accept. A requester may change them while not accepted.

## Structure
- Shared package alu_pkg holds:
  - ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - Flag bit indices FLG_V=3, FLG_C=2, FLG_Z=1, FLG_N=0.
  - An is_legal_ctrl function.
- One sub-module: the existing ALU, instantiated once. Its ports A, B, ALUControl, Result, V, C, Z and N are wired to the granted operands and to the capture logic.
- Arbiter, ready generation and response register are inline.

## Test plan
- Port 0 only: a=5, b=7, ctrl=000 -> next cycle rsp_valid=1, result=12, flags=0000, id=0, illegal=0.
- Both ports valid for 4 cycles with rsp_ready=1 and RR_INIT=0 -> rsp_id sequence 0,1,0,1 with no gaps.
- Port 1 sub: a=0x80000000, b=1, ctrl=001 -> result=0x7FFFFFFF, flags V=1 C=0 Z=0 N=0.
- slt (101): a=3, b=5 -> result=1, then a=5, b=3 -> result=0. Illegal 110: a=9, b=9 -> result=0, Z=1, illegal=1.
- Backpressure: after one accept, hold rsp_ready=0 for 3 cycles with both ports valid -> both readys stay 0 and rsp outputs do not change. Raise rsp_ready -> drain and a new accept in the same cycle, rsp_valid stays 1.
- Reset mid-operation: assert rst low while rsp_valid=1 -> all outputs read 0 immediately. After release, both ports valid -> the RR_INIT port is granted first.
